// File: rtl/step_stats_tracker.sv
// Fitness stats from a synchronized step pulse train and 1 Hz tick: steps, distance, window and high-run time.
// Optional display selector/mux enabled by defining DISP_MUX_EN.
module step_stats_tracker #(
    parameter int unsigned STEP_MAX     = 9999,
    parameter int unsigned HALF_MI_STEP = 1024,
    parameter int unsigned WINDOW_S     = 9,
    parameter int unsigned OVER_RATE    = 32,
    parameter int unsigned HI_RATE      = 64,
    parameter int unsigned HI_MIN_S     = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pulse,
    input  logic        clk_1hz,
    output logic [13:0] steps,
    output logic        steps_sat,
    output logic [7:0]  dist_halfmi,
    output logic [3:0]  over32_s,
    output logic [13:0] hi_time_s,
    output logic [1:0]  disp_sel,
    output logic [13:0] disp_value
);

    localparam int unsigned DIST_SHIFT = $clog2(HALF_MI_STEP);
    localparam logic [13:0] STEP_MAX_W = 14'(STEP_MAX);
    localparam logic [14:0] STEP_MAX_X = 15'(STEP_MAX);
    localparam logic [3:0]  WINDOW_W   = 4'(WINDOW_S);
    localparam logic [8:0]  OVER_W     = 9'(OVER_RATE);
    localparam logic [8:0]  HI_RATE_W  = 9'(HI_RATE);
    localparam logic [8:0]  HI_MIN_W   = 9'(HI_MIN_S);
    localparam logic [14:0] HI_MIN_X   = 15'(HI_MIN_S);

    logic [2:0]  pulse_sync;
    logic [2:0]  tick_sync;
    logic        step_rise;
    logic        tick_rise;

    logic [7:0]  sec_steps;
    logic [3:0]  sec_idx;
    logic [7:0]  run;

    logic [13:0] steps_next;
    logic [7:0]  sec_steps_next;
    logic [3:0]  sec_idx_next;
    logic [3:0]  over32_next;
    logic [7:0]  run_next;
    logic [13:0] hi_next;
    logic [8:0]  eff;
    logic [8:0]  run_inc;
    logic [14:0] hi_add;
    logic [14:0] hi_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_sync <= '0;
            tick_sync  <= '0;
        end else begin
            pulse_sync <= {pulse_sync[1:0], pulse};
            tick_sync  <= {tick_sync[1:0], clk_1hz};
        end
    end

    assign step_rise = pulse_sync[1] & ~pulse_sync[2];
    assign tick_rise = tick_sync[1] & ~tick_sync[2];

    // A step landing on the tick clock is counted into the closing second via eff.
    assign eff     = {1'b0, sec_steps} + {8'b0, step_rise};
    assign run_inc = {1'b0, run} + 9'd1;

    always_comb begin
        steps_next     = steps;
        sec_steps_next = sec_steps;
        sec_idx_next   = sec_idx;
        over32_next    = over32_s;
        run_next       = run;
        hi_add         = '0;

        if (step_rise && steps != STEP_MAX_W)
            steps_next = steps + 14'd1;

        if (tick_rise) begin
            sec_steps_next = '0;
            if (sec_idx < WINDOW_W) begin
                sec_idx_next = sec_idx + 4'd1;
                if (eff > OVER_W)
                    over32_next = over32_s + 4'd1;
            end
            if (eff >= HI_RATE_W) begin
                run_next = (run == 8'hFF) ? run : run_inc[7:0];
                if (run_inc == HI_MIN_W)
                    hi_add = HI_MIN_X;
                else if (run_inc > HI_MIN_W)
                    hi_add = 15'd1;
            end else begin
                run_next = '0;
            end
        end else if (step_rise && sec_steps != 8'hFF) begin
            sec_steps_next = sec_steps + 8'd1;
        end

        hi_sum  = {1'b0, hi_time_s} + hi_add;
        hi_next = (hi_sum > STEP_MAX_X) ? STEP_MAX_W : hi_sum[13:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            steps     <= '0;
            steps_sat <= 1'b0;
            sec_steps <= '0;
            sec_idx   <= '0;
            over32_s  <= '0;
            run       <= '0;
            hi_time_s <= '0;
        end else begin
            steps     <= steps_next;
            steps_sat <= steps_sat | (steps_next == STEP_MAX_W);
            sec_steps <= sec_steps_next;
            sec_idx   <= sec_idx_next;
            over32_s  <= over32_next;
            run       <= run_next;
            hi_time_s <= hi_next;
        end
    end

    assign dist_halfmi = 8'(steps >> DIST_SHIFT);

`ifdef DISP_MUX_EN
    // Selector moves every other tick so each stat is shown for two seconds.
    logic disp_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_phase <= 1'b0;
            disp_sel   <= '0;
            disp_value <= '0;
        end else begin
            if (tick_rise) begin
                disp_phase <= ~disp_phase;
                if (disp_phase)
                    disp_sel <= disp_sel + 2'd1;
            end
            case (disp_sel)
                2'd0:    disp_value <= steps;
                2'd1:    disp_value <= {6'b0, dist_halfmi};
                2'd2:    disp_value <= {10'b0, over32_s};
                default: disp_value <= hi_time_s;
            endcase
        end
    end
`else
    assign disp_sel   = '0;
    assign disp_value = '0;
`endif

endmodule

// File: tb/tb_step_stats_tracker.sv
// Directed self-checking bench for step_stats_tracker (default build; selector checks when DISP_MUX_EN is defined).
module tb_step_stats_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse = 1'b0;
    logic        clk_1hz = 1'b0;
    logic [13:0] steps;
    logic        steps_sat;
    logic [7:0]  dist_halfmi;
    logic [3:0]  over32_s;
    logic [13:0] hi_time_s;
    logic [1:0]  disp_sel;
    logic [13:0] disp_value;

    int checks = 0;
    int failures = 0;

    step_stats_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .pulse      (pulse),
        .clk_1hz    (clk_1hz),
        .steps      (steps),
        .steps_sat  (steps_sat),
        .dist_halfmi(dist_halfmi),
        .over32_s   (over32_s),
        .hi_time_s  (hi_time_s),
        .disp_sel   (disp_sel),
        .disp_value (disp_value)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pulse = 1'b0;
        clk_1hz = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pulse = 1'b1;
            cyc(1);
            pulse = 1'b0;
            cyc(1);
        end
    endtask

    task automatic tick();
        clk_1hz = 1'b1;
        cyc(1);
        clk_1hz = 1'b0;
        cyc(5);
    endtask

    initial begin
        cyc(1);
        do_reset();
        chk("reset_steps", steps, 0);
        chk("reset_sat", steps_sat, 0);
        chk("reset_over32", over32_s, 0);
        chk("reset_hi", hi_time_s, 0);

        // 1: basic count and first-window second
        pulses(50);
        tick();
        chk("t1_steps", steps, 50);
        chk("t1_over32", over32_s, 1);
        chk("t1_hi", hi_time_s, 0);
        chk("t1_dist", dist_halfmi, 0);
        chk("t1_sat", steps_sat, 0);
`ifndef DISP_MUX_EN
        chk("t1_disp_sel", disp_sel, 0);
        chk("t1_disp_value", disp_value, 0);
`endif

        // 2: exactly 32 per second never counts
        do_reset();
        for (int s = 0; s < 64; s++) begin
            pulses(32);
            tick();
        end
        chk("t2_steps", steps, 2048);
        chk("t2_dist", dist_halfmi, 2);
        chk("t2_over32", over32_s, 0);

        // 3: saturation, rate stats keep running
        do_reset();
        pulses(10005);
        cyc(4);
        chk("t3_steps", steps, 9999);
        chk("t3_sat", steps_sat, 1);
        chk("t3_dist", dist_halfmi, 9);
        tick();
        chk("t3_over32_a", over32_s, 1);
        pulses(40);
        tick();
        chk("t3_steps_hold", steps, 9999);
        chk("t3_over32_b", over32_s, 2);

        // 4: high-activity run crediting
        do_reset();
        for (int s = 1; s <= 60; s++) begin
            pulses(64);
            tick();
            if (s == 59) chk("t4_hi_59", hi_time_s, 0);
            if (s == 60) chk("t4_hi_60", hi_time_s, 60);
        end
        pulses(64);
        tick();
        chk("t4_hi_61", hi_time_s, 61);
        pulses(63);
        tick();
        chk("t4_hi_break", hi_time_s, 61);
        for (int s = 0; s < 59; s++) begin
            pulses(64);
            tick();
        end
        chk("t4_hi_short_run", hi_time_s, 61);

        // 5: window closes after WINDOW_S seconds
        do_reset();
        for (int s = 1; s <= 12; s++) begin
            pulses(40);
            tick();
            if (s == 9) chk("t5_over32_9", over32_s, 9);
        end
        chk("t5_over32_12", over32_s, 9);

        // 5b: step coincident with tick belongs to the closing second
        do_reset();
        pulses(32);
        cyc(2);
        pulse = 1'b1;
        clk_1hz = 1'b1;
        cyc(1);
        pulse = 1'b0;
        clk_1hz = 1'b0;
        cyc(5);
        chk("t5_coinc_over32", over32_s, 1);
        chk("t5_coinc_steps", steps, 33);
        tick();
        chk("t5_next_sec_empty", over32_s, 1);

        // 6: reset mid-run
        do_reset();
        pulses(500);
        cyc(4);
        chk("t6_steps_pre", steps, 500);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_steps", steps, 0);
        chk("t6_sat", steps_sat, 0);
        chk("t6_dist", dist_halfmi, 0);
        chk("t6_over32", over32_s, 0);
        chk("t6_hi", hi_time_s, 0);
        chk("t6_disp_sel", disp_sel, 0);
        chk("t6_disp_value", disp_value, 0);
        rst = 1'b0;
        cyc(1);

`ifdef DISP_MUX_EN
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("disp_sel_seq", disp_sel, (k / 2) % 4);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
